// File: rtl/ram_pkg.sv
// Shared constants and types for the dual-port RAM.
// The sequencer state enum is only consumed when RAM_DP_CLEAR_EN is defined.
package ram_pkg;

    localparam int RDW_OLD    = 0;
    localparam int RDW_NEW    = 1;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 12;

    typedef enum logic {
        CLEAR,
        READY
    } seq_state_t;

endpackage

// File: rtl/ram_clear_seq.sv
// Power-on clear sequencer: sweeps every address once after reset, then parks in READY.
// Only instantiated by ram_dp when RAM_DP_CLEAR_EN is defined.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              ready
);

    seq_state_t        state;
    seq_state_t        next_state;
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (state == CLEAR) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // The last address is written on the same edge that moves us to READY.
    always_comb begin
        next_state = state;
        wr_en      = 1'b0;
        wr_addr    = cnt;
        ready      = 1'b0;
        case (state)
            CLEAR: begin
                wr_en = 1'b1;
                if (cnt == '1) begin
                    next_state = READY;
                end
            end
            READY: begin
                ready = 1'b1;
            end
            default: begin
                next_state = CLEAR;
            end
        endcase
    end

endmodule

// File: rtl/ram_dp.sv
// True dual-port synchronous RAM with registered outputs and cross-port collision forwarding.
// Define RAM_DP_CLEAR_EN to fill the array with CLR_VAL after every reset before accepting requests.
module ram_dp
    import ram_pkg::*;
#(
    parameter int                 DATA_W   = DEF_DATA_W,
    parameter int                 ADDR_W   = DEF_ADDR_W,
    parameter int                 RDW_MODE = RDW_OLD,
    parameter logic [DATA_W-1:0]  CLR_VAL  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_en,
    input  logic              a_wren,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic [DATA_W-1:0] a_q,
    output logic              a_qv,
    input  logic              b_en,
    input  logic              b_wren,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic [DATA_W-1:0] b_q,
    output logic              b_qv,
    output logic              ready
);

    localparam int DEPTH = 1 << ADDR_W;

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

`ifdef RAM_DP_CLEAR_EN
    ram_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (clr_we),
        .wr_addr (clr_addr),
        .ready   (ready)
    );
`else
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
    assign ready    = 1'b1;
`endif

    logic a_rd_acc, a_wr_acc, b_rd_acc, b_wr_acc;

    assign a_rd_acc = a_en & ready & ~a_wren;
    assign a_wr_acc = a_en & ready &  a_wren;
    assign b_rd_acc = b_en & ready & ~b_wren;
    assign b_wr_acc = b_en & ready &  b_wren;

    // The clear sequencer borrows port A's write path; user requests are blocked while it runs.
    logic              a_we;
    logic [ADDR_W-1:0] a_waddr;
    logic [DATA_W-1:0] a_wdata;

    assign a_we    = clr_we | a_wr_acc;
    assign a_waddr = clr_we ? clr_addr : a_addr;
    assign a_wdata = clr_we ? CLR_VAL  : a_data;

    logic [DATA_W-1:0] mem [DEPTH];

    // Port A is written last so it wins a same-address dual write.
    always_ff @(posedge clk) begin
        if (b_wr_acc) begin
            mem[b_addr] <= b_data;
        end
        if (a_we) begin
            mem[a_waddr] <= a_wdata;
        end
    end

    logic [DATA_W-1:0] a_rd, b_rd;
    logic [DATA_W-1:0] a_fwd_data, b_fwd_data;
    logic              a_fwd, b_fwd;
    logic              fwd_on;

    assign fwd_on = (RDW_MODE == RDW_NEW);

    // Array reads return pre-write contents; the forwarding registers supply new-data mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rd       <= '0;
            b_rd       <= '0;
            a_fwd      <= 1'b0;
            b_fwd      <= 1'b0;
            a_fwd_data <= '0;
            b_fwd_data <= '0;
            a_qv       <= 1'b0;
            b_qv       <= 1'b0;
        end else begin
            a_qv <= a_rd_acc;
            b_qv <= b_rd_acc;
            if (a_rd_acc) begin
                a_rd       <= mem[a_addr];
                a_fwd      <= fwd_on & b_wr_acc & (b_addr == a_addr);
                a_fwd_data <= b_data;
            end
            if (b_rd_acc) begin
                b_rd       <= mem[b_addr];
                b_fwd      <= fwd_on & a_wr_acc & (a_addr == b_addr);
                b_fwd_data <= a_data;
            end
        end
    end

    assign a_q = a_fwd ? a_fwd_data : a_rd;
    assign b_q = b_fwd ? b_fwd_data : b_rd;

endmodule

// File: tb/tb_ram_dp.sv
// Directed testbench for ram_dp; exercises the power-on clear when RAM_DP_CLEAR_EN is defined.
module tb_ram_dp;
    import ram_pkg::*;

    localparam int DW  = 16;
    localparam int AW  = 6;
    localparam int RDW = RDW_OLD;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_en, a_wren, b_en, b_wren;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;
    logic [DW-1:0] a_q, b_q;
    logic          a_qv, b_qv, ready;

    int compared = 0;
    int mismatched = 0;

    ram_dp #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .RDW_MODE (RDW),
        .CLR_VAL  ('0)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_en   (a_en),
        .a_wren (a_wren),
        .a_addr (a_addr),
        .a_data (a_data),
        .a_q    (a_q),
        .a_qv   (a_qv),
        .b_en   (b_en),
        .b_wren (b_wren),
        .b_addr (b_addr),
        .b_data (b_data),
        .b_q    (b_q),
        .b_qv   (b_qv),
        .ready  (ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_en = 1'b0; a_wren = 1'b0; a_addr = '0; a_data = '0;
        b_en = 1'b0; b_wren = 1'b0; b_addr = '0; b_data = '0;
    endtask

    task automatic write_a(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        idle();
        a_en = 1'b1; a_wren = 1'b1; a_addr = addr; a_data = data;
        tick();
        idle();
    endtask

    task automatic read_a(input logic [AW-1:0] addr);
        idle();
        a_en = 1'b1; a_addr = addr;
        tick();
        idle();
    endtask

    // Counts edges from reset release until ready; returns DEPTH+20 if it never comes.
    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < DEPTH + 20) begin
            tick();
            n++;
            compared++;
            if (a_qv !== 1'b0 || b_qv !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL clear_qv: cycle %0d a_qv=%b b_qv=%b expected 0", n, a_qv, b_qv);
            end
        end
    endtask

    task automatic test_reset();
        int n;
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        compared++;
        if (a_q !== '0 || b_q !== '0 || a_qv !== 1'b0 || b_qv !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: a_q=%h b_q=%h a_qv=%b b_qv=%b expected all 0", a_q, b_q, a_qv, b_qv);
        end
`ifdef RAM_DP_CLEAR_EN
        compared++;
        if (ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_ready: got %b expected 0", ready);
        end
        // Requests hammer address 0 during the clear; they must have no effect.
        rst_n = 1'b1;
        a_en = 1'b1; a_wren = 1'b1; a_addr = '0; a_data = 16'hDEAD;
        b_en = 1'b1; b_wren = 1'b0; b_addr = '0;
        wait_ready(n);
        idle();
        compared++;
        if (n != DEPTH) begin
            mismatched++;
            $display("[TB] FAIL clear_time: got %0d cycles expected %0d", n, DEPTH);
        end
`else
        rst_n = 1'b1;
        #1;
        compared++;
        if (ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_ready: got %b expected 1", ready);
        end
`endif
    endtask

`ifdef RAM_DP_CLEAR_EN
    task automatic test_clear_contents();
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            a_en = 1'b1; a_addr = AW'(i);
            b_en = 1'b1; b_addr = AW'(DEPTH - 1 - i);
            tick();
            compared++;
            if (a_q !== '0 || b_q !== '0 || a_qv !== 1'b1 || b_qv !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL clear_contents[%0d]: a_q=%h b_q=%h qv=%b%b expected 0000 0000 11", i, a_q, b_q, a_qv, b_qv);
            end
        end
        idle();
    endtask
`endif

    task automatic test_basic();
        write_a(6'h05, 16'hBEEF);
        b_en = 1'b1; b_addr = 6'h05;
        tick();
        idle();
        compared++;
        if (b_q !== 16'hBEEF || b_qv !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL basic_read: b_q=%h b_qv=%b expected BEEF 1", b_q, b_qv);
        end
        tick();
        compared++;
        if (b_q !== 16'hBEEF || b_qv !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL basic_idle_hold: b_q=%h b_qv=%b expected BEEF 0", b_q, b_qv);
        end
    endtask

    task automatic test_collision();
        logic [DW-1:0] exp_q;
        exp_q = (RDW == RDW_NEW) ? 16'h2222 : 16'h1111;
        write_a(6'h10, 16'h1111);
        a_en = 1'b1; a_wren = 1'b1; a_addr = 6'h10; a_data = 16'h2222;
        b_en = 1'b1; b_wren = 1'b0; b_addr = 6'h10;
        tick();
        idle();
        compared++;
        if (b_q !== exp_q || b_qv !== 1'b1 || a_qv !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL collision_b_read: b_q=%h b_qv=%b a_qv=%b expected %h 1 0", b_q, b_qv, a_qv, exp_q);
        end
        // Mirror case: B writes while A reads the same word.
        exp_q = (RDW == RDW_NEW) ? 16'h3333 : 16'h2222;
        a_en = 1'b1; a_wren = 1'b0; a_addr = 6'h10;
        b_en = 1'b1; b_wren = 1'b1; b_addr = 6'h10; b_data = 16'h3333;
        tick();
        idle();
        compared++;
        if (a_q !== exp_q || a_qv !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL collision_a_read: a_q=%h a_qv=%b expected %h 1", a_q, a_qv, exp_q);
        end
        read_a(6'h10);
        compared++;
        if (a_q !== 16'h3333) begin
            mismatched++;
            $display("[TB] FAIL collision_after: a_q=%h expected 3333", a_q);
        end
    endtask

    task automatic test_dual_write();
        a_en = 1'b1; a_wren = 1'b1; a_addr = 6'h20; a_data = 16'hAAAA;
        b_en = 1'b1; b_wren = 1'b1; b_addr = 6'h20; b_data = 16'h5555;
        tick();
        idle();
        b_en = 1'b1; b_addr = 6'h20;
        tick();
        idle();
        compared++;
        if (b_q !== 16'hAAAA || b_qv !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL dual_write: b_q=%h b_qv=%b expected AAAA 1", b_q, b_qv);
        end
    endtask

    task automatic test_hold();
        write_a(6'h01, 16'h1234);
        read_a(6'h01);
        compared++;
        if (a_q !== 16'h1234 || a_qv !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL hold_read: a_q=%h a_qv=%b expected 1234 1", a_q, a_qv);
        end
        write_a(6'h01, 16'h9999);
        compared++;
        if (a_q !== 16'h1234 || a_qv !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL hold_after_write: a_q=%h a_qv=%b expected 1234 0", a_q, a_qv);
        end
        read_a(6'h01);
        compared++;
        if (a_q !== 16'h9999) begin
            mismatched++;
            $display("[TB] FAIL hold_readback: a_q=%h expected 9999", a_q);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vals [4];
        vals[0] = 16'h0F0F; vals[1] = 16'hF00D; vals[2] = 16'h8001; vals[3] = 16'h7FFE;
        for (int i = 0; i < 4; i++) begin
            write_a(AW'(48 + i), vals[i]);
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            b_en = 1'b1; b_addr = AW'(48 + i);
            tick();
            compared++;
            if (b_q !== vals[i] || b_qv !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL b2b_read[%0d]: b_q=%h b_qv=%b expected %h 1", i, b_q, b_qv, vals[i]);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_mid_reset();
        int n;
        read_a(6'h05);
        compared++;
        if (a_q !== 16'hBEEF) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_pre: a_q=%h expected BEEF", a_q);
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if (a_q !== '0 || a_qv !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL async_reset: a_q=%h a_qv=%b expected 0 0", a_q, a_qv);
        end
        tick();
`ifdef RAM_DP_CLEAR_EN
        rst_n = 1'b1;
        a_en = 1'b1; a_wren = 1'b1; a_addr = 6'h05; a_data = 16'h7777;
        b_en = 1'b1; b_wren = 1'b0; b_addr = 6'h05;
        for (int i = 0; i < 7; i++) begin
            tick();
            compared++;
            if (a_qv !== 1'b0 || b_qv !== 1'b0 || ready !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL mid_clear_req[%0d]: a_qv=%b b_qv=%b ready=%b expected 0 0 0", i, a_qv, b_qv, ready);
            end
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if (a_q !== '0 || b_q !== '0 || ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL mid_clear_reset: a_q=%h b_q=%h ready=%b expected 0 0 0", a_q, b_q, ready);
        end
        tick();
        rst_n = 1'b1;
        wait_ready(n);
        idle();
        compared++;
        if (n != DEPTH) begin
            mismatched++;
            $display("[TB] FAIL restart_clear_time: got %0d cycles expected %0d", n, DEPTH);
        end
        read_a(6'h05);
        compared++;
        if (a_q !== '0 || a_qv !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL recleared_word: a_q=%h a_qv=%b expected 0000 1", a_q, a_qv);
        end
`else
        rst_n = 1'b1;
        read_a(6'h05);
        compared++;
        if (a_q !== 16'hBEEF || a_qv !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL array_survives_reset: a_q=%h a_qv=%b expected BEEF 1", a_q, a_qv);
        end
`endif
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        test_reset();
`ifdef RAM_DP_CLEAR_EN
        test_clear_contents();
`endif
        test_basic();
        test_collision();
        test_dual_write();
        test_hold();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ram_dp.md
RAM_DP -- requirements
Module: ram_dp

Interface
REQ-001 Parameter DATA_W, default 16, word width in bits.
REQ-002 Parameter ADDR_W, default 12, address width; depth = 2**ADDR_W words.
REQ-003 Parameter RDW_MODE, default 0, cross-port read-during-write result: 0 = old data, 1 = new data.
REQ-004 Parameter CLR_VAL, default all-zeros (DATA_W bits), fill word written by the clear sequencer.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 a_en  input  1  port A access request.
REQ-008 a_wren  input  1  port A write (1) or read (0) when a_en=1.
REQ-009 a_addr  input  ADDR_W  port A word address.
REQ-010 a_data  input  DATA_W  port A write data.
REQ-011 a_q  output  DATA_W  port A registered read data.
REQ-012 a_qv  output  1  port A read-data-valid strobe.
REQ-013 b_en, b_wren, b_addr, b_data, b_q, b_qv SHALL mirror the port A signals in direction, width and meaning, for port B.
REQ-014 ready  output  1  memory accepts requests.

Function
REQ-015 Both ports SHALL be synchronous, fully independent read/write ports on one shared array of depth 2**ADDR_W.
REQ-016 Read: a request accepted at edge N SHALL drive x_q = mem[addr] and x_qv = 1 after edge N; x_qv SHALL be 0 in every cycle without an accepted read.
REQ-017 Write: mem[addr] <= data at the edge; the same port's x_q SHALL hold its previous value and x_qv = 0.
REQ-018 x_q SHALL hold its last value whenever no read is accepted on that port.
REQ-019 Requests SHALL be accepted only when ready=1; requests with ready=0 SHALL be ignored (no write, x_qv=0).
REQ-020 Same-address same-cycle cross-port read/write SHALL return the old word if RDW_MODE=0 and the written word if RDW_MODE=1.
REQ-021 Same-address same-cycle writes on both ports SHALL leave port A's data in memory.
REQ-022 Address arithmetic SHALL be modulo 2**ADDR_W; no out-of-range state exists.

Reset
REQ-023 Reset SHALL force a_q = b_q = 0, a_qv = b_qv = 0 and the clear sequencer to CLEAR at address 0.
REQ-024 The memory array SHALL NOT be reset by rst_n.
REQ-025 Reset asserted mid-clear SHALL restart the clear from address 0 on release.

Configuration
REQ-026 Macro RAM_DP_CLEAR_EN SHALL select the power-on clear.
REQ-027 With RAM_DP_CLEAR_EN defined: FSM CLEAR writes CLR_VAL to one address per cycle, 0 to 2**ADDR_W-1, then enters READY; ready = 0 in CLEAR and 1 in READY.
REQ-028 Total clear time SHALL be exactly 2**ADDR_W cycles after reset release; READY SHALL be terminal until the next reset.
REQ-029 Without RAM_DP_CLEAR_EN: no sequencer; ready = 1 from reset release; array contents undefined until written.

Structure
REQ-030 Package ram_pkg SHALL hold the RDW_OLD/RDW_NEW constants, the default widths and the sequencer state enum (CLEAR, READY).
REQ-031 The clear sequencer SHALL be a sub-module ram_clear_seq (outputs: wr_en, wr_addr, ready), included only under RAM_DP_CLEAR_EN.
REQ-032 The array SHALL be coded for block-RAM inference; collision forwarding logic SHALL sit outside the array.

Verification
REQ-033 Clear: RAM_DP_CLEAR_EN, ADDR_W=4, reset release -> ready=0 for exactly 16 cycles, then 1; reading all 16 addresses returns 0.
REQ-034 Basic: write A addr 0x005 data 0xBEEF, then read B addr 0x005 -> b_q=0xBEEF with b_qv=1 one edge after the request.
REQ-035 Collision: mem[0x010]=0x1111; same cycle A writes 0x2222 and B reads 0x010 -> b_q=0x1111 (RDW_MODE=0) or 0x2222 (RDW_MODE=1).
REQ-036 Dual write: A writes 0xAAAA and B writes 0x5555 to 0x020 in one cycle -> a later read returns 0xAAAA.
REQ-037 Mid-clear reset: rst_n low at clear cycle 7 -> outputs 0; after release, ready rises exactly 2**ADDR_W cycles later; requests during clear are ignored with x_qv=0.
REQ-038 Hold: A reads 0x001 (0x1234), then A writes 0x001 with 0x9999 -> a_q stays 0x1234 and a_qv=0 after the write.
